// File: rtl/keypad_scan4x4.sv
// 4x4 matrix keypad scanner: column strobe, per-scan debounce FSM,
// hex decode and a 32-bit shift register of entered digits.
module keypad_scan4x4 #(
    parameter int SCAN_DIV_W     = 10,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  i_row,
    output logic [3:0]  o_col,
    input  logic        cs,
    input  logic        clr,
    output logic [31:0] o_data,
    output logic [3:0]  o_key,
    output logic        o_valid,
    output logic        o_key_pulse
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DS = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    logic [3:0]            row_meta;
    logic [3:0]            row_sync;
    logic [SCAN_DIV_W-1:0] div;
    logic                  tick;
    logic [1:0]            col;
    logic [1:0]            col_next;
    logic [15:0]           map;
    logic                  scan_done;

    assign tick     = &div;
    assign col_next = col + 2'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta  <= '1;
            row_sync  <= '1;
            div       <= '0;
            col       <= '0;
            o_col     <= 4'b1110;
            map       <= '0;
            scan_done <= 1'b0;
        end else begin
            row_meta  <= i_row;
            row_sync  <= row_meta;
            div       <= div + 1'b1;
            scan_done <= tick && (col == 2'd3);
            if (tick) begin
                map[{col, 2'b00} +: 4] <= ~row_sync;
                col   <= col_next;
                o_col <= ~(4'b0001 << col_next);
            end
        end
    end

    // map bit j holds row j[1:0] of column j[3:2]
    logic [4:0] nbits;
    logic [3:0] hit;
    logic       one;
    logic       none;
    logic [3:0] code;

    always_comb begin
        nbits = '0;
        hit   = '0;
        for (int j = 0; j < 16; j++) begin
            if (map[j]) begin
                nbits = nbits + 5'd1;
                hit   = 4'(j);
            end
        end
    end

    assign one  = (nbits == 5'd1);
    assign none = (nbits == 5'd0);

    always_comb begin
        code = 4'h0;
        unique case ({hit[1:0], hit[3:2]})
            4'd0:  code = 4'h1;
            4'd1:  code = 4'h2;
            4'd2:  code = 4'h3;
            4'd3:  code = 4'hA;
            4'd4:  code = 4'h4;
            4'd5:  code = 4'h5;
            4'd6:  code = 4'h6;
            4'd7:  code = 4'hB;
            4'd8:  code = 4'h7;
            4'd9:  code = 4'h8;
            4'd10: code = 4'h9;
            4'd11: code = 4'hC;
            4'd12: code = 4'hE;
            4'd13: code = 4'h0;
            4'd14: code = 4'hF;
            4'd15: code = 4'hD;
        endcase
    end

    state_t        state;
    state_t        state_n;
    logic [3:0]    cand;
    logic [3:0]    cand_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [CW-1:0] cnt_inc;
    logic          accept;

    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        if (scan_done) begin
            unique case (state)
                IDLE: if (one) begin
                    cand_n  = code;
                    cnt_n   = CW'(1);
                    state_n = (DS == CW'(1)) ? PRESSED : DEBOUNCE;
                end
                DEBOUNCE: begin
                    if (one && code == cand) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == DS) state_n = PRESSED;
                    end else if (one) begin
                        cand_n = code;
                        cnt_n  = CW'(1);
                    end else begin
                        state_n = IDLE;
                    end
                end
                PRESSED: if (none) begin
                    cnt_n   = CW'(1);
                    state_n = (DS == CW'(1)) ? IDLE : RELEASE;
                end
                RELEASE: begin
                    if (none) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == DS) state_n = IDLE;
                    end else begin
                        state_n = PRESSED;
                    end
                end
            endcase
        end
    end

    always_comb begin
        accept = 1'b0;
        if (scan_done && one) begin
            if (state == IDLE && DS == CW'(1)) accept = 1'b1;
            if (state == DEBOUNCE && code == cand && cnt_inc == DS) accept = 1'b1;
        end
    end

    // accept wins over a coincident cs; clr with accept keeps only the new digit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_data      <= '0;
            o_key       <= '0;
            o_valid     <= 1'b0;
            o_key_pulse <= 1'b0;
        end else begin
            o_key_pulse <= accept;
            if (accept) begin
                o_key   <= cand_n;
                o_valid <= 1'b1;
                o_data  <= clr ? {28'b0, cand_n} : {o_data[27:0], cand_n};
            end else begin
                if (cs)  o_valid <= 1'b0;
                if (clr) o_data  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan4x4.sv
// Directed bench for keypad_scan4x4 with a fast scan (4 clk/tick, 16 clk/scan).
module tb_keypad_scan4x4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  i_row;
    logic [3:0]  o_col;
    logic        cs = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] o_data;
    logic [3:0]  o_key;
    logic        o_valid;
    logic        o_key_pulse;
    logic [15:0] keys = '0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          pulses = 0;

    keypad_scan4x4 #(.SCAN_DIV_W(2), .DEBOUNCE_SCANS(3)) dut (
        .clk(clk), .reset(rst_n), .i_row(i_row), .o_col(o_col),
        .cs(cs), .clr(clr), .o_data(o_data), .o_key(o_key),
        .o_valid(o_valid), .o_key_pulse(o_key_pulse)
    );

    always #5 clk = ~clk;

    // key index r*4+c pulls row r low while column c is driven low
    always_comb begin
        i_row = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !o_col[c]) i_row[r] = 1'b0;
    end

    always @(negedge clk) if (o_key_pulse === 1'b1) pulses++;

    task automatic scans(input int n);
        repeat (n*16) @(negedge clk);
    endtask

    task automatic enter_key(input int k);
        keys = 16'(1) << k;
        scans(5);
        keys = '0;
        scans(4);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (o_col !== 4'b1110) begin n_fail++; $display("FAIL reset_col got %b exp 1110", o_col); end
        n_chk++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", o_data); end
        n_chk++; if (o_key !== 4'h0) begin n_fail++; $display("FAIL reset_key got %h exp 0", o_key); end
        n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", o_valid); end
        n_chk++; if (o_key_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got %b exp 0", o_key_pulse); end
    endtask

    task automatic test_idle_scan;
        logic [3:0] exp;
        rst_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            exp = ~(4'b0001 << ((n / 4) % 4));
            n_chk++;
            if (o_col !== exp) begin
                n_fail++;
                $display("FAIL col_seq n=%0d got %b exp %b", n, o_col, exp);
            end
        end
        scans(2);
        n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b exp 0", o_valid); end
        n_chk++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL idle_data got %h exp 0", o_data); end
        n_chk++; if (pulses !== 0) begin n_fail++; $display("FAIL idle_pulses got %0d exp 0", pulses); end
    endtask

    task automatic test_single_key;
        int p0;
        p0 = pulses;
        keys = 16'(1) << 6;
        scans(5);
        n_chk++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL key6_pulses got %0d exp 1", pulses - p0); end
        n_chk++; if (o_key !== 4'h6) begin n_fail++; $display("FAIL key6_key got %h exp 6", o_key); end
        n_chk++; if (o_data !== 32'h6) begin n_fail++; $display("FAIL key6_data got %h exp 6", o_data); end
        n_chk++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL key6_valid got %b exp 1", o_valid); end
        scans(3);
        n_chk++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL key6_held got %0d exp 1", pulses - p0); end
        keys = '0;
        scans(4);
    endtask

    task automatic test_bounce;
        int p0;
        p0 = pulses;
        keys = 16'(1) << 13;
        scans(1);
        keys = '0;
        scans(4);
        n_chk++; if (pulses - p0 !== 0) begin n_fail++; $display("FAIL bounce_pulses got %0d exp 0", pulses - p0); end
        n_chk++; if (o_data !== 32'h6) begin n_fail++; $display("FAIL bounce_data got %h exp 6", o_data); end
    endtask

    task automatic test_sequence;
        int ks[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        int p0;
        enter_key(13);
        n_chk++; if (o_data !== 32'h60) begin n_fail++; $display("FAIL seq_60 got %h exp 60", o_data); end
        n_chk++; if (o_key !== 4'h0) begin n_fail++; $display("FAIL seq_key0 got %h exp 0", o_key); end
        p0 = pulses;
        foreach (ks[i]) enter_key(ks[i]);
        n_chk++; if (pulses - p0 !== 9) begin n_fail++; $display("FAIL seq_pulses got %0d exp 9", pulses - p0); end
        n_chk++; if (o_data !== 32'h23456789) begin n_fail++; $display("FAIL seq_data got %h exp 23456789", o_data); end
        n_chk++; if (o_key !== 4'h9) begin n_fail++; $display("FAIL seq_key got %h exp 9", o_key); end
    endtask

    task automatic test_multi;
        int p0;
        p0 = pulses;
        keys = 16'h0003;
        scans(6);
        n_chk++; if (pulses - p0 !== 0) begin n_fail++; $display("FAIL multi_pulses got %0d exp 0", pulses - p0); end
        n_chk++; if (o_data !== 32'h23456789) begin n_fail++; $display("FAIL multi_data got %h exp 23456789", o_data); end
        keys = 16'h0001;
        scans(5);
        n_chk++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL multi_rel_pulses got %0d exp 1", pulses - p0); end
        n_chk++; if (o_key !== 4'h1) begin n_fail++; $display("FAIL multi_rel_key got %h exp 1", o_key); end
        n_chk++; if (o_data !== 32'h34567891) begin n_fail++; $display("FAIL multi_rel_data got %h exp 34567891", o_data); end
        keys = '0;
        scans(4);
    endtask

    task automatic test_cs_clr;
        int budget;
        @(negedge clk); cs = 1'b1;
        @(negedge clk); cs = 1'b0;
        n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL cs_valid got %b exp 0", o_valid); end
        n_chk++; if (o_data !== 32'h34567891) begin n_fail++; $display("FAIL cs_data got %h exp 34567891", o_data); end
        clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        n_chk++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL clr_data got %h exp 0", o_data); end
        // align to the clock right after a full-scan tick
        budget = 0;
        while (o_col !== 4'b0111 && budget < 64) begin @(negedge clk); budget++; end
        while (o_col !== 4'b1110 && budget < 64) begin @(negedge clk); budget++; end
        n_chk++; if (budget >= 64) begin n_fail++; $display("FAIL align_timeout got %0d exp <64", budget); end
        keys = 16'(1) << 5;
        repeat (48) @(negedge clk);
        cs = 1'b1; clr = 1'b1;
        @(negedge clk);
        cs = 1'b0; clr = 1'b0;
        n_chk++; if (o_key_pulse !== 1'b1) begin n_fail++; $display("FAIL acc_pulse got %b exp 1", o_key_pulse); end
        n_chk++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL acc_cs_valid got %b exp 1", o_valid); end
        n_chk++; if (o_data !== 32'h5) begin n_fail++; $display("FAIL acc_clr_data got %h exp 5", o_data); end
        n_chk++; if (o_key !== 4'h5) begin n_fail++; $display("FAIL acc_key got %h exp 5", o_key); end
        @(negedge clk);
        n_chk++; if (o_key_pulse !== 1'b0) begin n_fail++; $display("FAIL acc_pulse_width got %b exp 0", o_key_pulse); end
        n_chk++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL acc_valid_hold got %b exp 1", o_valid); end
        keys = '0;
        scans(4);
    endtask

    task automatic test_reset_mid;
        int p0;
        keys = 16'(1) << 10;
        scans(2);
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if (o_col !== 4'b1110) begin n_fail++; $display("FAIL mid_col got %b exp 1110", o_col); end
        n_chk++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL mid_data got %h exp 0", o_data); end
        n_chk++; if (o_key !== 4'h0) begin n_fail++; $display("FAIL mid_key got %h exp 0", o_key); end
        n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b exp 0", o_valid); end
        n_chk++; if (o_key_pulse !== 1'b0) begin n_fail++; $display("FAIL mid_pulse got %b exp 0", o_key_pulse); end
        keys = '0;
        repeat (3) @(negedge clk);
        p0 = pulses;
        rst_n = 1'b1;
        scans(5);
        n_chk++; if (pulses - p0 !== 0) begin n_fail++; $display("FAIL mid_after_pulses got %0d exp 0", pulses - p0); end
        n_chk++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL mid_after_data got %h exp 0", o_data); end
        n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after_valid got %b exp 0", o_valid); end
    endtask

    initial begin
        test_reset;
        test_idle_scan;
        test_single_key;
        test_bounce;
        test_sequence;
        test_multi;
        test_cs_clr;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
